// File: rtl/l2_cache.sv
// Direct-mapped, write-back / write-allocate L2 cache with 64-byte lines.
// Serves one L1 request at a time; backing memory is accessed a whole line per transfer.
module l2_cache #(
  parameter int HIT_LAT = 4,
  parameter int SETS    = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  L2_addr,
  input  logic [31:0]  L2_wdata,
  input  logic         L2_renable,
  input  logic         L2_wenable,
  output logic         L2_stall,
  output logic [0:511] L1_block,
  output logic [31:0]  mem_addr,
  output logic         mem_renable,
  output logic         mem_wenable,
  output logic [0:511] mem_wline,
  input  logic [0:511] mem_rline,
  input  logic         mem_ready,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 6 - IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WBACK,
    FILL,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             req_we;
  logic [3:0]       lat_cnt;

  logic [SETS-1:0]  valid;
  logic [SETS-1:0]  dirty;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [0:511]     data_mem [SETS];

  logic [0:511]     line_buf;
  logic [0:511]     l1_hold;
  logic [0:511]     merged;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [8:0]       bit_base;
  logic             lookup_end;
  logic             hit;

  assign req_idx    = req_addr[6 +: IDX_W];
  assign req_tag    = req_addr[31 -: TAG_W];
  assign bit_base   = {req_addr[5:0], 3'b000};
  assign lookup_end = (state == LOOKUP) && (lat_cnt == 4'(HIT_LAT - 1));
  assign hit        = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  // The most significant byte of the write word lands on the lowest byte address.
  always_comb begin
    merged = line_buf;
    if (req_we) begin
      merged[bit_base          +: 8] = req_wdata[31:24];
      merged[bit_base + 9'd8   +: 8] = req_wdata[23:16];
      merged[bit_base + 9'd16  +: 8] = req_wdata[15:8];
      merged[bit_base + 9'd24  +: 8] = req_wdata[7:0];
    end
  end

  assign L1_block = (state == DONE) ? merged : l1_hold;

  always_comb begin
    state_nxt   = state;
    L2_stall    = 1'b0;
    mem_renable = 1'b0;
    mem_wenable = 1'b0;
    mem_addr    = '0;
    mem_wline   = '0;
    case (state)
      IDLE: begin
        if (L2_renable) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        L2_stall = 1'b1;
        if (lookup_end) begin
          if (hit)                                  state_nxt = DONE;
          else if (valid[req_idx] && dirty[req_idx]) state_nxt = WBACK;
          else                                      state_nxt = FILL;
        end
      end
      WBACK: begin
        L2_stall    = 1'b1;
        mem_wenable = 1'b1;
        mem_addr    = {tag_mem[req_idx], req_idx, 6'b0};
        mem_wline   = line_buf;
        if (mem_ready) state_nxt = FILL;
      end
      FILL: begin
        L2_stall    = 1'b1;
        mem_renable = 1'b1;
        mem_addr    = {req_tag, req_idx, 6'b0};
        if (mem_ready) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
      lat_cnt   <= '0;
      valid     <= '0;
      dirty     <= '0;
      l1_hold   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (L2_renable) begin
            req_addr  <= L2_addr & ~32'h3;
            req_wdata <= L2_wdata;
            req_we    <= L2_wenable;
            lat_cnt   <= '0;
          end
        end
        LOOKUP: begin
          if (!lookup_end) begin
            lat_cnt <= lat_cnt + 4'd1;
          end else if (hit) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
          end
        end
        WBACK: begin
          if (mem_ready) dirty[req_idx] <= 1'b0;
        end
        FILL: begin
          if (mem_ready) begin
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
          end
        end
        DONE: begin
          l1_hold <= merged;
          if (req_we) dirty[req_idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (state == LOOKUP) line_buf <= data_mem[req_idx];
    if (state == FILL && mem_ready) begin
      line_buf          <= mem_rline;
      data_mem[req_idx] <= mem_rline;
      tag_mem[req_idx]  <= req_tag;
    end
    if (state == DONE && req_we) data_mem[req_idx] <= merged;
  end

endmodule

// File: tb/tb_l2_cache.sv
// Directed self-checking bench for l2_cache; a simple line memory answers
// each transfer after a fixed number of wait cycles and logs what it saw.
module tb_l2_cache;

  localparam int HIT_LAT  = 4;
  localparam int MEM_WAIT = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  L2_addr = '0;
  logic [31:0]  L2_wdata = '0;
  logic         L2_renable = 1'b0;
  logic         L2_wenable = 1'b0;
  logic         L2_stall;
  logic [0:511] L1_block;
  logic [31:0]  mem_addr;
  logic         mem_renable;
  logic         mem_wenable;
  logic [0:511] mem_wline;
  logic [0:511] mem_rline = '0;
  logic         mem_ready = 1'b0;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int checks = 0;
  int errors = 0;

  bit           mem_hold = 1'b0;
  int           wait_ctr = 0;
  int           both_err = 0;
  int           ev_n = 0;
  bit           ev_wb   [32];
  logic [31:0]  ev_addr [32];
  logic [0:511] ev_line [32];

  l2_cache #(.HIT_LAT(HIT_LAT), .SETS(512)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .L2_addr    (L2_addr),
    .L2_wdata   (L2_wdata),
    .L2_renable (L2_renable),
    .L2_wenable (L2_wenable),
    .L2_stall   (L2_stall),
    .L1_block   (L1_block),
    .mem_addr   (mem_addr),
    .mem_renable(mem_renable),
    .mem_wenable(mem_wenable),
    .mem_wline  (mem_wline),
    .mem_rline  (mem_rline),
    .mem_ready  (mem_ready),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [0:511] make_line(input logic [31:0] a);
    logic [0:511] l;
    for (int i = 0; i < 64; i++) l[8*i +: 8] = 8'(i) ^ a[23:16] ^ a[15:8] ^ a[7:0];
    return l;
  endfunction

  // Memory model: answers a transfer after MEM_WAIT strobe cycles and logs it.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (mem_renable && mem_wenable) both_err++;
    if (rst_n && (mem_renable || mem_wenable) && !mem_hold) begin
      if (mem_renable) mem_rline = make_line(mem_addr);
      if (wait_ctr == MEM_WAIT) begin
        mem_ready = 1'b1;
        wait_ctr  = 0;
        if (ev_n < 32) begin
          ev_wb[ev_n]   = mem_wenable;
          ev_addr[ev_n] = mem_addr;
          ev_line[ev_n] = mem_wline;
        end
        ev_n++;
      end else begin
        wait_ctr++;
      end
    end else begin
      wait_ctr = 0;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input bit scramble, output int stall_cycles);
    bit done;
    done = 1'b0;
    @(negedge clk);
    L2_addr    = a;
    L2_wdata   = d;
    L2_wenable = we;
    L2_renable = 1'b1;
    @(posedge clk);
    stall_cycles = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (scramble && n == 0) begin
        L2_addr    = 32'hFFFF_FFC0;
        L2_wdata   = 32'h0BAD_F00D;
        L2_wenable = ~we;
      end
      if (!L2_stall) done = 1'b1;
      else stall_cycles++;
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL request_timeout addr=%h stall still high after 200 cycles", a);
    end
    L2_renable = 1'b0;
    L2_wenable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (L2_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b exp=0", L2_stall); end
    checks++; if (mem_renable !== 1'b0 || mem_wenable !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en got=%b%b exp=00", mem_renable, mem_wenable); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wline !== '0) begin errors++; $display("[TB] FAIL reset_mem_wline got=%h exp=0", mem_wline); end
    checks++; if (L1_block !== '0) begin errors++; $display("[TB] FAIL reset_l1_block got=%h exp=0", L1_block); end
    checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_counters got=%h/%h exp=0/0", hit_cnt, miss_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_cold_read();
    int sc, e0;
    logic [0:511] p;
    p  = make_line(32'h0000_0040);
    e0 = ev_n;
    issue(32'h0000_0040, 32'h0, 1'b0, 1'b0, sc);
    checks++; if (ev_n !== e0 + 1 || ev_wb[e0] !== 1'b0 || ev_addr[e0] !== 32'h0000_0040) begin errors++; $display("[TB] FAIL cold_fill events=%0d wb=%b addr=%h exp 1 fill at 00000040", ev_n - e0, ev_wb[e0], ev_addr[e0]); end
    checks++; if (L1_block !== p) begin errors++; $display("[TB] FAIL cold_l1_block got=%h exp=%h", L1_block, p); end
    checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin errors++; $display("[TB] FAIL cold_counters got=%0d/%0d exp=0/1", hit_cnt, miss_cnt); end
    checks++; if (sc !== HIT_LAT + MEM_WAIT + 1) begin errors++; $display("[TB] FAIL cold_latency got=%0d exp=%0d", sc, HIT_LAT + MEM_WAIT + 1); end
    @(negedge clk);
    checks++; if (L1_block !== p) begin errors++; $display("[TB] FAIL cold_l1_hold got=%h exp=%h", L1_block, p); end
  endtask

  task automatic test_hit_read();
    int sc, e0;
    e0 = ev_n;
    issue(32'h0000_0044, 32'h0, 1'b0, 1'b0, sc);
    checks++; if (ev_n !== e0) begin errors++; $display("[TB] FAIL hit_no_mem got=%0d transfers exp=0", ev_n - e0); end
    checks++; if (sc !== HIT_LAT) begin errors++; $display("[TB] FAIL hit_latency got=%0d exp=%0d", sc, HIT_LAT); end
    checks++; if (hit_cnt !== 32'd1) begin errors++; $display("[TB] FAIL hit_cnt got=%0d exp=1", hit_cnt); end
    checks++; if (L1_block !== make_line(32'h0000_0040)) begin errors++; $display("[TB] FAIL hit_l1_block got=%h", L1_block); end
  endtask

  task automatic test_write_back();
    int sc, e0;
    logic [0:511] exp_mod;
    exp_mod = make_line(32'h0000_0040);
    exp_mod[64 +: 8] = 8'hDE;
    exp_mod[72 +: 8] = 8'hAD;
    exp_mod[80 +: 8] = 8'hBE;
    exp_mod[88 +: 8] = 8'hEF;
    issue(32'h0000_0048, 32'hDEAD_BEEF, 1'b1, 1'b0, sc);
    checks++; if (L1_block !== exp_mod) begin errors++; $display("[TB] FAIL write_hit_block got=%h exp=%h", L1_block, exp_mod); end
    checks++; if (hit_cnt !== 32'd2 || sc !== HIT_LAT) begin errors++; $display("[TB] FAIL write_hit_stats hit=%0d lat=%0d exp 2/%0d", hit_cnt, sc, HIT_LAT); end
    e0 = ev_n;
    issue(32'h0000_8040, 32'h0, 1'b0, 1'b0, sc);
    checks++; if (ev_n !== e0 + 2) begin errors++; $display("[TB] FAIL evict_transfers got=%0d exp=2", ev_n - e0); end
    checks++; if (ev_wb[e0] !== 1'b1 || ev_addr[e0] !== 32'h0000_0040) begin errors++; $display("[TB] FAIL evict_wback wb=%b addr=%h exp 1/00000040", ev_wb[e0], ev_addr[e0]); end
    checks++; if (ev_line[e0] !== exp_mod) begin errors++; $display("[TB] FAIL evict_wline got=%h exp=%h", ev_line[e0], exp_mod); end
    checks++; if (ev_wb[e0+1] !== 1'b0 || ev_addr[e0+1] !== 32'h0000_8040) begin errors++; $display("[TB] FAIL evict_fill wb=%b addr=%h exp 0/00008040", ev_wb[e0+1], ev_addr[e0+1]); end
    checks++; if (L1_block !== make_line(32'h0000_8040)) begin errors++; $display("[TB] FAIL evict_l1_block got=%h", L1_block); end
    checks++; if (miss_cnt !== 32'd2 || sc !== HIT_LAT + 2*(MEM_WAIT + 1)) begin errors++; $display("[TB] FAIL evict_stats miss=%0d lat=%0d exp 2/%0d", miss_cnt, sc, HIT_LAT + 2*(MEM_WAIT + 1)); end
  endtask

  task automatic test_unaligned_write();
    int sc;
    logic [0:511] exp_l;
    exp_l = make_line(32'h0000_0100);
    exp_l[0  +: 8] = 8'h11;
    exp_l[8  +: 8] = 8'h22;
    exp_l[16 +: 8] = 8'h33;
    exp_l[24 +: 8] = 8'h44;
    issue(32'h0000_0103, 32'h1122_3344, 1'b1, 1'b0, sc);
    checks++; if (L1_block !== exp_l) begin errors++; $display("[TB] FAIL unaligned_block got=%h exp=%h", L1_block, exp_l); end
    checks++; if (miss_cnt !== 32'd3) begin errors++; $display("[TB] FAIL unaligned_miss got=%0d exp=3", miss_cnt); end
    issue(32'h0000_0104, 32'h0, 1'b0, 1'b1, sc);
    checks++; if (L1_block !== exp_l) begin errors++; $display("[TB] FAIL ignore_inputs_block got=%h exp=%h", L1_block, exp_l); end
    checks++; if (hit_cnt !== 32'd3) begin errors++; $display("[TB] FAIL ignore_inputs_hit got=%0d exp=3", hit_cnt); end
  endtask

  task automatic test_reset_fill();
    int sc, e0;
    bit seen;
    seen = 1'b0;
    mem_hold = 1'b1;
    @(negedge clk);
    L2_addr    = 32'h0000_0180;
    L2_renable = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      L2_renable = 1'b0;
      if (mem_renable) seen = 1'b1;
    end
    checks++; if (!seen || mem_addr !== 32'h0000_0180) begin errors++; $display("[TB] FAIL fill_wait seen=%b addr=%h exp 1/00000180", seen, mem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_renable !== 1'b0 || L2_stall !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL abort_outputs ren=%b stall=%b addr=%h exp 0/0/0", mem_renable, L2_stall, mem_addr); end
    checks++; if (miss_cnt !== 32'h0 || L1_block !== '0) begin errors++; $display("[TB] FAIL abort_state miss=%0d l1=%h exp 0/0", miss_cnt, L1_block); end
    mem_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    e0 = ev_n;
    issue(32'h0000_0180, 32'h0, 1'b0, 1'b0, sc);
    checks++; if (ev_n !== e0 + 1 || ev_addr[e0] !== 32'h0000_0180 || miss_cnt !== 32'd1) begin errors++; $display("[TB] FAIL refetch events=%0d addr=%h miss=%0d exp 1/00000180/1", ev_n - e0, ev_addr[e0], miss_cnt); end
    checks++; if (L1_block !== make_line(32'h0000_0180)) begin errors++; $display("[TB] FAIL refetch_block got=%h", L1_block); end
    e0 = ev_n;
    issue(32'h0000_8040, 32'h0, 1'b0, 1'b0, sc);
    checks++; if (ev_n !== e0 + 1 || ev_wb[e0] !== 1'b0 || miss_cnt !== 32'd2) begin errors++; $display("[TB] FAIL cold_after_reset events=%0d wb=%b miss=%0d exp 1/0/2", ev_n - e0, ev_wb[e0], miss_cnt); end
  endtask

  task automatic test_saturation();
    int sc;
    @(negedge clk);
    force dut.miss_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.miss_cnt;
    issue(32'h0001_0000, 32'h0, 1'b0, 1'b0, sc);
    checks++; if (miss_cnt !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL sat_reach got=%h exp=ffffffff", miss_cnt); end
    issue(32'h0002_0000, 32'h0, 1'b0, 1'b0, sc);
    checks++; if (miss_cnt !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL sat_hold got=%h exp=ffffffff", miss_cnt); end
    checks++; if (L1_block !== make_line(32'h0002_0000)) begin errors++; $display("[TB] FAIL sat_block got=%h", L1_block); end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_hit_read();
    test_write_back();
    test_unaligned_write();
    test_reset_fill();
    test_saturation();
    checks++; if (both_err !== 0) begin errors++; $display("[TB] FAIL mem_strobe_overlap got=%0d exp=0", both_err); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
